scram_tx_datapath: RTL and testbench

- Transmit-side scrambler datapath, directly downstream of the 16-bit keystream LFSR.
- Accepts data words with valid/ready and XORs each word with one keystream word.
- Drives the LFSR control inputs: key_seed_n goes to the LFSR sync reseed input; key_req goes to the LFSR enable.
- Reseeds the keystream at every start-of-frame, so the receiver can realign per frame.

---
 rtl/scram_tx_datapath_pkg.sv | 13 +
 rtl/scram_tx_datapath.sv | 125 ++++++++++++
 tb/tb_scram_tx_datapath.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scram_tx_datapath_pkg.sv
// Shared types and constants for the transmit scrambler datapath.
package scram_tx_datapath_pkg;

  localparam int SCRAM_W = 16;
  localparam logic [SCRAM_W-1:0] SCRAM_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    SEED = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/scram_tx_datapath.sv
// Transmit scrambler: XORs each accepted word with one LFSR keystream word,
// reseeding the keystream at every start-of-frame.
module scram_tx_datapath
  import scram_tx_datapath_pkg::*;
#(
  parameter int WIDTH         = SCRAM_W,
  parameter bit SEED_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_bypass,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sof,
  output logic             key_seed_n,
  output logic             key_req,
  input  logic [WIDTH-1:0] key_in
);

  localparam state_e RESET_STATE = SEED_ON_RESET ? SEED : RUN;

  state_e             state_r;
  state_e             state_nxt_s;
  logic [WIDTH-1:0]   key_reg_r;
  logic               key_vld_r;
  logic               key_pend_r;
  logic               fresh_r;
  logic [WIDTH-1:0]   cur_key_s;
  logic               key_avail_s;
  logic               ready_s;
  logic               accept_s;
  logic               reseed_s;

  // Next-state, handshake and LFSR control decode.
  always_comb begin
    key_seed_n  = 1'b1;
    key_req     = 1'b0;
    ready_s     = 1'b0;
    accept_s    = 1'b0;
    reseed_s    = 1'b0;
    state_nxt_s = state_r;
    // key_in is only meaningful the cycle after a request; otherwise use the held copy
    cur_key_s   = key_pend_r ? key_in : key_reg_r;
    key_avail_s = key_pend_r | key_vld_r;
    case (state_r)
      SEED: begin
        key_seed_n  = 1'b0;
        state_nxt_s = FILL;
      end
      FILL: begin
        key_req     = 1'b1;
        state_nxt_s = RUN;
      end
      RUN: begin
        ready_s  = key_avail_s & (~out_valid | out_ready) & ~(in_sof & ~fresh_r);
        accept_s = in_valid & ready_s;
        reseed_s = in_valid & in_sof & ~fresh_r;
        key_req  = accept_s;
        if (reseed_s) begin
          state_nxt_s = SEED;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = RESET_STATE;
      end
    endcase
    in_ready = ready_s;
  end

  // State and keystream prefetch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RESET_STATE;
      key_reg_r  <= '0;
      key_vld_r  <= 1'b0;
      key_pend_r <= 1'b0;
      fresh_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == FILL) begin
        key_pend_r <= 1'b1;
        key_vld_r  <= 1'b0;
        fresh_r    <= 1'b1;
      end else if (reseed_s) begin
        key_pend_r <= 1'b0;
        key_vld_r  <= 1'b0;
      end else if (accept_s) begin
        key_pend_r <= 1'b1;
        key_vld_r  <= 1'b0;
        fresh_r    <= 1'b0;
      end else if ((state_r == RUN) && key_pend_r) begin
        key_reg_r  <= key_in;
        key_vld_r  <= 1'b1;
        key_pend_r <= 1'b0;
      end else begin
        key_pend_r <= key_pend_r;
      end
    end
  end

  // Output register with valid/ready hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_data  <= cfg_bypass ? in_data : (in_data ^ cur_key_s);
      out_sof   <= in_sof;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_scram_tx_datapath.sv
// Self-checking bench for scram_tx_datapath with an attached behavioural LFSR
// (seed 16'hFFFF, left-shift Galois, taps 16'h9870, so FFFF is followed by 678E).
module tb_scram_tx_datapath;

  localparam logic [15:0] POLY = 16'h9870;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_bypass;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_sof;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sof;
  logic        key_seed_n;
  logic        key_req;
  logic [15:0] key_in;

  always #5 clk = ~clk;

  scram_tx_datapath #(.WIDTH(16), .SEED_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_bypass(cfg_bypass),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
    .key_seed_n(key_seed_n), .key_req(key_req), .key_in(key_in)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_mode = 0;
  int frame_idx = 0;
  int seed_lows = 0;
  logic [15:0] exp_q[$];
  logic        exp_sof_q[$];
  logic [15:0] got_q[$];
  int          acc_cyc_q[$];
  logic [15:0] lfsr_st;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000);
  endfunction

  // n-th keystream word of a frame, counted from the seed
  function automatic logic [15:0] key_at(input int n);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int i = 0; i < n; i++) s = lfsr_next(s);
    return s;
  endfunction

  // Attached LFSR: reseed on key_seed_n, output current state on request, 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_st <= 16'hFFFF;
      key_in  <= 16'h0000;
    end else if (!key_seed_n) begin
      lfsr_st <= 16'hFFFF;
      key_in  <= 16'h0000;
    end else if (key_req) begin
      key_in  <= lfsr_st;
      lfsr_st <= lfsr_next(lfsr_st);
    end else begin
      key_in  <= 16'h0000;
    end
  end

  // Output monitor: scoreboard compare and stall stability.
  initial begin
    logic [15:0] hold_d;
    logic [15:0] e;
    logic        s;
    bit          hold_v;
    hold_v = 1'b0;
    hold_d = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          checks++;
          if (!out_valid || out_data !== hold_d) begin
            errors++;
            $display("FAIL stall_hold: valid=%0b data=%h required valid=1 data=%h", out_valid, out_data, hold_d);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: data=%h with no word pending", out_data);
          end else begin
            e = exp_q.pop_front();
            s = exp_sof_q.pop_front();
            if (out_data !== e || out_sof !== s) begin
              errors++;
              $display("FAIL out_word: data=%h sof=%0b required data=%h sof=%0b", out_data, out_sof, e, s);
            end
            got_q.push_back(out_data);
          end
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 2 == 0);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic send_word(input logic [15:0] d, input logic sof, input logic byp, input int gap);
    bit done;
    done = 1'b0;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1; in_data = d; in_sof = sof; cfg_bypass = byp;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (!key_seed_n) seed_lows++;
      if (in_ready) begin
        if (sof) frame_idx = 0;
        exp_q.push_back(byp ? d : (d ^ key_at(frame_idx)));
        exp_sof_q.push_back(sof);
        frame_idx++;
        acc_cyc_q.push_back(cyc);
        done = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    cfg_bypass = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout: word %h not accepted, required accept within 40 cycles", d);
    end
  endtask

  task automatic drain();
    int t;
    ready_mode = 0;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 60) begin
      step();
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; in_sof = 1'b0;
    cfg_bypass = 1'b0; out_ready = 1'b1; ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: %b required 0", out_valid); end
    if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: %h required 0000", out_data); end
    if (out_sof !== 1'b0) begin errors++; $display("FAIL reset_out_sof: %b required 0", out_sof); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: %b required 0", in_ready); end
    if (key_seed_n !== 1'b0) begin errors++; $display("FAIL reset_seed_state: key_seed_n=%b required 0", key_seed_n); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    got_q.delete(); acc_cyc_q.delete();
    send_word(16'h0000, 1'b1, 1'b0, 0);
    send_word(16'h0000, 1'b0, 1'b0, 0);
    drain();
    checks += 2;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL basic_count: %0d words required 2", got_q.size());
    end else begin
      if (got_q[0] !== 16'hFFFF || got_q[1] !== 16'h678E) begin
        errors++; $display("FAIL basic_keys: %h %h required ffff 678e", got_q[0], got_q[1]);
      end
    end
    if (acc_cyc_q.size() != 2 || acc_cyc_q[1] - acc_cyc_q[0] != 1) begin
      errors++; $display("FAIL basic_throughput: accepts not on consecutive cycles, required 1 cycle apart");
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    ready_mode = 1;
    for (int i = 0; i < 8; i++) send_word(16'($urandom), (i == 0), 1'b0, 0);
    drain();
    checks++;
    if (got_q.size() != 8) begin
      errors++; $display("FAIL b2b_count: %0d words required 8", got_q.size());
    end
  endtask

  task automatic test_gaps();
    logic [15:0] d[4];
    got_q.delete();
    for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) send_word(d[i], (i == 0), 1'b0, 3);
    drain();
    checks++;
    if (got_q.size() != 4 || got_q[0] !== (d[0] ^ 16'hFFFF) || got_q[1] !== (d[1] ^ 16'h678E)) begin
      errors++; $display("FAIL gaps_keys: first outputs not scrambled with ffff, 678e in order");
    end
  endtask

  task automatic test_midstream_sof();
    logic [15:0] d[6];
    got_q.delete();
    ready_mode = 2;
    for (int i = 0; i < 6; i++) d[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) send_word(d[i], (i == 0), 1'b0, 0);
    seed_lows = 0;
    send_word(d[4], 1'b1, 1'b0, 0);
    checks++;
    if (seed_lows != 1) begin
      errors++; $display("FAIL midsof_seed_pulse: key_seed_n low %0d cycles required 1", seed_lows);
    end
    send_word(d[5], 1'b0, 1'b0, 0);
    drain();
    checks++;
    if (got_q.size() != 6 || got_q[4] !== (d[4] ^ 16'hFFFF) || got_q[5] !== (d[5] ^ 16'h678E)) begin
      errors++; $display("FAIL midsof_keys: words 5/6 not scrambled with ffff/678e");
    end
  endtask

  task automatic test_bypass();
    logic [15:0] d[5];
    got_q.delete();
    ready_mode = 2;
    for (int i = 0; i < 5; i++) d[i] = 16'($urandom);
    for (int i = 0; i < 5; i++) send_word(d[i], (i == 0), (i == 1 || i == 2), 0);
    drain();
    checks++;
    if (got_q.size() != 5 || got_q[1] !== d[1] || got_q[2] !== d[2] || got_q[3] !== (d[3] ^ key_at(3))) begin
      errors++; $display("FAIL bypass: bypassed words altered or word 4 not using 4th key");
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    ready_mode = 3;
    send_word(16'($urandom), 1'b1, 1'b0, 0);
    step();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: out_valid=%b required 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async: out_valid=%b required 0", out_valid); end
    exp_q.delete(); exp_sof_q.delete(); got_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    step();
    d = 16'($urandom);
    send_word(d, 1'b1, 1'b0, 0);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== (d ^ 16'hFFFF)) begin
      errors++; $display("FAIL rstmid_reseed: first word after reset not scrambled with ffff");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_midstream_sof();
    test_bypass();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
